// File: rtl/gmii_tx_arbiter.sv
// gmii_tx_arbiter
//   Packet-granular round-robin arbiter that shares one GMII transmit MAC
//   between NUM_PORTS AXI-Stream packet sources. A grant is held from a
//   packet's first beat until its tlast handshake, so packets never interleave.
//   It also counts completed packets per port.
//
// Ports
//   clk, aresetn          : clock, asynchronous active-low reset
//   s_axis_t*             : port-major slave AXIS bundle (slice i = port i)
//   m_axis_t*             : single master AXIS port towards the MAC
//   port_enable           : per-port arbitration enable (sampled in IDLE only)
//   grant                 : one-hot current owner, 0 when idle
//   busy                  : high while a packet is in flight (FSM state PKT)
//   pkt_count             : per-port completed-packet counters, port-major
//
// Handshake: a beat transfers on any rising edge where tvalid && tready.
// Valid never depends on ready; ready of the granted source is the MAC's
// ready passed straight through, all other readys are held low.
module gmii_tx_arbiter #(
    parameter int AXIS_BYTES = 1,
    parameter int NUM_PORTS  = 4,
    parameter int CTR_WIDTH  = 16
) (
    input  logic                              clk,
    input  logic                              aresetn,
    input  logic [NUM_PORTS-1:0]              s_axis_tvalid,
    output logic [NUM_PORTS-1:0]              s_axis_tready,
    input  logic [NUM_PORTS*AXIS_BYTES*8-1:0] s_axis_tdata,
    input  logic [NUM_PORTS*AXIS_BYTES-1:0]   s_axis_tkeep,
    input  logic [NUM_PORTS-1:0]              s_axis_tlast,
    output logic                              m_axis_tvalid,
    input  logic                              m_axis_tready,
    output logic [AXIS_BYTES*8-1:0]           m_axis_tdata,
    output logic [AXIS_BYTES-1:0]             m_axis_tkeep,
    output logic                              m_axis_tlast,
    input  logic [NUM_PORTS-1:0]              port_enable,
    output logic [NUM_PORTS-1:0]              grant,
    output logic                              busy,
    output logic [NUM_PORTS*CTR_WIDTH-1:0]    pkt_count
);

    localparam int DW = AXIS_BYTES * 8;
    localparam int IW = $clog2(NUM_PORTS);

    typedef enum logic {
        IDLE = 1'b0,
        PKT  = 1'b1
    } state_t;

    state_t               state_q, state_d;
    logic [NUM_PORTS-1:0] grant_q, grant_d;
    logic [IW-1:0]        last_q, last_d;     // last winner; also the index muxed in PKT
    logic [CTR_WIDTH-1:0] cnt_q [NUM_PORTS];
    logic [1:0]           rst_sync_q;
    logic                 rst_n;

    logic [NUM_PORTS-1:0] req;
    logic                 found;
    logic [IW-1:0]        win;
    logic                 pkt_done;

    // Reset asserts asynchronously everywhere but is released on a clock edge.
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) rst_sync_q <= 2'b00;
        else          rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
    assign rst_n = rst_sync_q[1];

    // Round-robin search starting just above the previous winner, wrapping.
    always_comb begin
        int cand;
        cand  = 0;
        req   = s_axis_tvalid & port_enable;
        found = 1'b0;
        win   = last_q;
        for (int i = 1; i <= NUM_PORTS; i++) begin
            cand = (int'(last_q) + i) % NUM_PORTS;
            if (!found && req[cand]) begin
                found = 1'b1;
                win   = IW'(cand);
            end
        end
    end

    assign pkt_done = (state_q == PKT) && m_axis_tvalid && m_axis_tready && m_axis_tlast;

    // Next-state logic
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        last_d  = last_q;
        case (state_q)
            IDLE: begin
                if (found) begin
                    state_d      = PKT;
                    grant_d      = '0;
                    grant_d[win] = 1'b1;
                    last_d       = win;
                end
            end
            PKT: begin
                if (pkt_done) begin
                    state_d = IDLE;
                    grant_d = '0;
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            grant_q <= '0;
            last_q  <= IW'(NUM_PORTS - 1);   // port 0 wins the first arbitration
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_PORTS; i++) cnt_q[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_PORTS; i++) begin
                if (pkt_done && grant_q[i]) cnt_q[i] <= cnt_q[i] + CTR_WIDTH'(1);
            end
        end
    end

    // Zero-latency datapath. Valid and readys are gated by state so they drop
    // as soon as reset forces IDLE, without waiting for a clock.
    always_comb begin
        m_axis_tvalid = (state_q == PKT) && s_axis_tvalid[last_q];
        m_axis_tdata  = s_axis_tdata[int'(last_q)*DW +: DW];
        m_axis_tkeep  = s_axis_tkeep[int'(last_q)*AXIS_BYTES +: AXIS_BYTES];
        m_axis_tlast  = s_axis_tlast[last_q];
        for (int i = 0; i < NUM_PORTS; i++) begin
            s_axis_tready[i] = (state_q == PKT) && grant_q[i] && m_axis_tready;
        end
    end

    always_comb begin
        pkt_count = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            pkt_count[i*CTR_WIDTH +: CTR_WIDTH] = cnt_q[i];
        end
    end

    assign grant = grant_q;
    assign busy  = (state_q == PKT);

endmodule

// File: doc/gmii_tx_arbiter.md
# gmii_tx_arbiter

Packet-granular round-robin arbiter that shares one GMII transmit MAC between several AXI-Stream packet sources. It sits between per-source packet FIFOs and the MAC's AXIS input. Once a packet is granted, the grant is held until that packet's `tlast` is accepted, so the MAC never sees interleaved packets. It also keeps per-source transmitted-packet counters for status.

## Interface
Parameters:
- `AXIS_BYTES`, 1, bytes per beat on every port; must match the MAC.
- `NUM_PORTS`, 4, number of requesting sources; 2..16.
- `CTR_WIDTH`, 16, width of each per-port packet counter.

Ports (the `s_axis_*` ports are port-major: bits for port `i` occupy slice `i`):
- `clk` in 1: the only clock; all logic is synchronous to its rising edge.
- `aresetn` in 1: asynchronous, active-low reset.
- `s_axis_tvalid` in `NUM_PORTS`: per-port valid.
- `s_axis_tready` out `NUM_PORTS`: per-port ready.
- `s_axis_tdata` in `NUM_PORTS*AXIS_BYTES*8`: per-port data.
- `s_axis_tkeep` in `NUM_PORTS*AXIS_BYTES`: per-port byte keep.
- `s_axis_tlast` in `NUM_PORTS`: per-port last.
- `m_axis_tvalid`, `m_axis_tready`, `m_axis_tdata`, `m_axis_tkeep`, `m_axis_tlast`: single master AXIS port to the MAC. `tready` is an input; all others are outputs.
- `port_enable` in `NUM_PORTS`: a port takes part in arbitration only while its bit is 1.
- `grant` out `NUM_PORTS`: one-hot current owner; 0 when idle.
- `busy` out 1: high while a packet is in flight (state `PKT`).
- `pkt_count` out `NUM_PORTS*CTR_WIDTH`: per-port count of completed packets.

## Operation
- Source contract: each source holds `tvalid` high from the first beat to `tlast`. The arbiter forwards valid unmodified and adds no gaps, which preserves the MAC's no-bubble requirement.
- State `IDLE`:
  - `grant` = 0, all `s_axis_tready` = 0, `m_axis_tvalid` = 0.
  - Each cycle, compute `req = s_axis_tvalid & port_enable`.
  - If `req` != 0, select the first set bit searching upward from `(last + 1) mod NUM_PORTS`, wrapping.
  - Register the winner into `grant` and `last`, and go to `PKT`.
- State `PKT`, with `g` = granted index:
  - `m_axis_*` = slice `g` of the `s_axis_*` inputs (combinational mux).
  - `s_axis_tready[g] = m_axis_tready`; all other readys = 0.
  - On `m_axis_tvalid & m_axis_tready & m_axis_tlast`: `pkt_count[g]` increments modulo 2^`CTR_WIDTH` and the next state is `IDLE`.
- Round-robin fairness: after port `k` is served, port `k` has the lowest priority in the next arbitration.
- `port_enable` is sampled only in `IDLE`. Deasserting the granted port's enable mid-packet does not abort the packet.
- Requests from ungranted ports while in `PKT` are held off (their ready = 0). No request is lost.
- A single-beat packet (`tlast` on the first beat) is legal: `PKT` lasts exactly one handshake cycle.
- `tdata`/`tkeep` are passed through untouched; no packing or checking is done.

## Timing
- Reset (async assert, sync-released internally):
  - `state` = `IDLE`, `grant` = 0, `last` = `NUM_PORTS-1` (so port 0 wins first), `busy` = 0.
  - All `pkt_count` = 0.
  - `m_axis_tvalid` = 0 and all `s_axis_tready` = 0 immediately, combinationally from `state`.
- Reset mid-packet abandons the packet. The source FIFO is responsible for flushing it.
- Grant latency: `req` seen in `IDLE` on cycle n → `grant` and `busy` valid from cycle n+1; the first beat is presentable at `m_axis` in cycle n+1.
- Inter-packet overhead: exactly 1 `IDLE` cycle between the `tlast` handshake and the next packet's first beat.
- Datapath latency: 0 cycles; the mux and ready path are purely combinational.
- `pkt_count[g]` shows the new value in the cycle after the `tlast` handshake.
- Backpressure: `m_axis_tready` low stalls the granted source only. The grant is never changed while stalled.
- Counter wrap: all-ones + 1 → 0 with no sticky flag.

## Test plan
- Single port: port 1 sends a 64-byte packet (`AXIS_BYTES`=1) with the others idle.
  - `grant` = 0b0010 from the cycle after `tvalid`.
  - 64 beats are forwarded with no gaps.
  - `pkt_count[1]` = 1 afterwards; `busy` drops the cycle after `tlast`.
- Contention: all 4 ports continuously valid, 3 packets each.
  - Grant order is 0,1,2,3,0,1,2,3,...
  - Exactly 1 idle cycle separates consecutive packets.
  - Every `pkt_count` = 3.
- Enable mask: `port_enable` = 0b1010 with all ports valid → only ports 1 and 3 are granted, alternating; ports 0 and 2 see `tready` = 0 throughout.
- Mid-packet disable and backpressure: clear `port_enable[g]` and toggle `m_axis_tready` every other cycle during the packet.
  - The packet completes intact in order.
  - No other port receives `tready`.
- Async reset asserted mid-packet:
  - `m_axis_tvalid`, `grant`, and all `s_axis_tready` go to 0 without a clock edge.
  - Counters = 0.
  - After release, port 0 wins the first arbitration.
- Counter wrap: `CTR_WIDTH`=2, port 2 sends 5 one-beat packets → `pkt_count[2]` sequence 1,2,3,0,1.
